// File: rtl/spi_dummy_secondary.sv
`default_nettype none
// ============================================================================
// spi_dummy_secondary: oversampled SPI mode-0 secondary emulating a sensor
// Revision: 1.0
// ============================================================================
module spi_dummy_secondary #(
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mosi,
    output logic miso,
    input  logic sclk,
    input  logic cs
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_t;

    localparam logic [4:0] C_CMD_LAST_BIT  = 5'd7;
    localparam logic [4:0] C_DATA_LAST_BIT = 5'd15;
    localparam logic [4:0] C_FULL_FRAME    = 5'd16;
    localparam logic [1:0] C_ADDR_ID       = 2'd0;
    localparam logic [1:0] C_ADDR_SCRATCH  = 2'd1;
    localparam logic [1:0] C_ADDR_CTRL     = 2'd2;
    localparam logic [1:0] C_ADDR_XFER     = 2'd3;

    logic [1:0] r_sclk_sync;
    logic [1:0] r_mosi_sync;
    logic [1:0] r_cs_sync;
    logic       r_sclk_prev;
    logic       r_cs_prev;

    state_t     r_state;
    state_t     w_state_next;

    logic [4:0] r_bit_cnt;
    logic [6:0] r_rx;
    logic [7:0] r_tx;
    logic       r_miso_bit;
    logic       r_is_read;
    logic [1:0] r_addr;

    logic [7:0] r_scratch;
    logic [7:0] r_ctrl;
    logic [7:0] r_xfer_cnt;

    logic       w_cs_high;
    logic       w_sclk_s;
    logic       w_mosi_s;
    logic       w_cs_fall;
    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_frame_start;
    logic       w_frame_end;
    logic       w_bit_rise;
    logic       w_bit_fall;
    logic       w_cmd_done;
    logic       w_data_done;
    logic       w_cmd_read;
    logic [1:0] w_cmd_addr;
    logic [7:0] w_wr_data;
    logic [7:0] w_rd_data;
    logic       w_write_en;

    // Synchronizers reset low so a frame already in progress at reset release
    // never looks like cs having been high; arming needs a real high on cs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_cs_sync   <= 2'b00;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], sclk};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_cs_sync   <= {r_cs_sync[0], cs};
            r_sclk_prev <= r_sclk_sync[1];
            r_cs_prev   <= r_cs_sync[1];
        end
    end

    assign w_cs_high   = r_cs_sync[1];
    assign w_sclk_s    = r_sclk_sync[1];
    assign w_mosi_s    = r_mosi_sync[1];
    assign w_cs_fall   = ~w_cs_high & r_cs_prev;
    // sclk edges are dropped while cs is high, so cs deassertion wins a tie
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev & ~w_cs_high;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_prev & ~w_cs_high;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_DISARMED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_DISARMED: if (w_cs_high) w_state_next = ST_IDLE;
            ST_IDLE:     if (w_cs_fall) w_state_next = ST_ACTIVE;
            ST_ACTIVE:   if (w_cs_high) w_state_next = ST_IDLE;
            default:     w_state_next = ST_DISARMED;
        endcase
    end

    assign w_frame_start = (r_state == ST_IDLE) & w_cs_fall;
    assign w_frame_end   = (r_state == ST_ACTIVE) & w_cs_high;
    assign w_bit_rise    = (r_state == ST_ACTIVE) & w_sclk_rise;
    assign w_bit_fall    = (r_state == ST_ACTIVE) & w_sclk_fall;
    assign w_cmd_done    = w_bit_rise & (r_bit_cnt == C_CMD_LAST_BIT);
    assign w_data_done   = w_bit_rise & (r_bit_cnt == C_DATA_LAST_BIT);

    // Completed byte is the seven bits already shifted in plus the current one
    assign w_cmd_read = r_rx[6];
    assign w_cmd_addr = {r_rx[0], w_mosi_s};
    assign w_wr_data  = {r_rx, w_mosi_s};
    assign w_write_en = w_data_done & ~r_is_read;

    always_comb begin
        w_rd_data = 8'h00;
        case (w_cmd_addr)
            C_ADDR_ID:      w_rd_data = ID_VALUE;
            C_ADDR_SCRATCH: w_rd_data = r_scratch;
            C_ADDR_CTRL:    w_rd_data = r_ctrl;
            C_ADDR_XFER:    w_rd_data = r_xfer_cnt;
            default:        w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= 5'd0;
            r_rx       <= 7'd0;
            r_tx       <= 8'h00;
            r_miso_bit <= 1'b0;
            r_is_read  <= 1'b0;
            r_addr     <= 2'd0;
        end else if (w_frame_start) begin
            // ID MSB goes out immediately; the rest follows on falling edges
            r_bit_cnt  <= 5'd0;
            r_tx       <= {ID_VALUE[6:0], 1'b0};
            r_miso_bit <= ID_VALUE[7];
        end else begin
            if (w_bit_rise) begin
                r_rx <= {r_rx[5:0], w_mosi_s};
                if (r_bit_cnt != C_FULL_FRAME) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
                if (w_cmd_done) begin
                    r_is_read <= w_cmd_read;
                    r_addr    <= w_cmd_addr;
                    r_tx      <= w_cmd_read ? w_rd_data : 8'h00;
                end
            end
            if (w_bit_fall) begin
                r_miso_bit <= (r_bit_cnt >= C_FULL_FRAME) ? 1'b0 : r_tx[7];
                r_tx       <= {r_tx[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scratch  <= 8'h00;
            r_ctrl     <= 8'h00;
            r_xfer_cnt <= 8'h00;
        end else begin
            if (w_write_en && (r_addr == C_ADDR_SCRATCH)) begin
                r_scratch <= w_wr_data;
            end
            if (w_write_en && (r_addr == C_ADDR_CTRL)) begin
                r_ctrl <= w_wr_data;
            end
            if (w_frame_end && (r_bit_cnt == C_FULL_FRAME)) begin
                r_xfer_cnt <= r_xfer_cnt + 8'd1;
            end
        end
    end

    // Raw cs gates the driver so release of a shared line is immediate
    assign miso = cs ? 1'bz : r_miso_bit;

endmodule
`default_nettype wire

// File: tb/tb_spi_dummy_secondary.sv
`default_nettype none
// ============================================================================
// tb_spi_dummy_secondary: two secondaries on a shared pulled-up MISO line
// Revision: 1.0
// ============================================================================
module tb_spi_dummy_secondary;

    localparam logic [7:0] C_ID0 = 8'hA5;
    localparam logic [7:0] C_ID1 = 8'h5A;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic mosi  = 1'b0;
    logic sclk  = 1'b0;
    logic cs0   = 1'b1;
    logic cs1   = 1'b1;
    wire  miso_bus;
    wire  cs_all_high;

    pullup (miso_bus);
    assign cs_all_high = cs0 & cs1;

    spi_dummy_secondary #(.ID_VALUE(C_ID0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .mosi  (mosi),
        .miso  (miso_bus),
        .sclk  (sclk),
        .cs    (cs0)
    );

    spi_dummy_secondary #(.ID_VALUE(C_ID1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .mosi  (mosi),
        .miso  (miso_bus),
        .sclk  (sclk),
        .cs    (cs1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents per instance
    logic [7:0] m_scratch [2];
    logic [7:0] m_ctrl    [2];
    logic [7:0] m_xfer    [2];
    logic [7:0] exp_q [$];

    function automatic logic [7:0] model_id(input int inst);
        return (inst == 0) ? C_ID0 : C_ID1;
    endfunction

    function automatic logic [7:0] model_read(input int inst, input logic [1:0] a);
        case (a)
            2'd0:    return model_id(inst);
            2'd1:    return m_scratch[inst];
            2'd2:    return m_ctrl[inst];
            default: return m_xfer[inst];
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_scratch[k] = 8'h00;
            m_ctrl[k]    = 8'h00;
            m_xfer[k]    = 8'h00;
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, got, exp);
        end
    endtask

    // Monitor: primary-side view, sampling MISO on each sclk rise
    logic [7:0] mon_sh  = 8'h00;
    int         mon_cnt = 0;

    always @(negedge cs_all_high) mon_cnt = 0;

    always @(posedge sclk) begin
        if (!cs_all_high) begin
            mon_sh = {mon_sh[6:0], miso_bus};
            mon_cnt++;
            if (mon_cnt % 8 == 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL miso_byte got %02h expected none", mon_sh);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (mon_sh !== e) begin
                        errors++;
                        $display("FAIL miso_byte got %02h expected %02h", mon_sh, e);
                    end
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cs(input int inst, input logic v);
        if (inst == 0) cs0 = v;
        else           cs1 = v;
    endtask

    task automatic sclk_pulse(input logic b);
        mosi = b;
        wait_clk(5);
        sclk = 1'b1;
        wait_clk(6);
        sclk = 1'b0;
    endtask

    // One frame of nbits bits (0..24); below 16 bits it is an aborted frame
    task automatic frame(input int inst, input logic [7:0] cmd,
                         input logic [7:0] data, input int nbits);
        logic [23:0] bits;
        logic [7:0]  resp;
        bits = {cmd, data, 8'($urandom)};
        resp = cmd[7] ? model_read(inst, cmd[1:0]) : 8'h00;
        if (nbits >= 8)  exp_q.push_back(model_id(inst));
        if (nbits >= 16) exp_q.push_back(resp);
        if (nbits >= 24) exp_q.push_back(8'h00);
        wait_clk(1);
        set_cs(inst, 1'b0);
        wait_clk(6);
        for (int i = 0; i < nbits; i++) sclk_pulse(bits[23-i]);
        wait_clk(6);
        set_cs(inst, 1'b1);
        wait_clk(6);
        check_bit("miso_released", miso_bus, 1'b1);
        if (nbits >= 16) begin
            if (!cmd[7] && cmd[1:0] == 2'd1) m_scratch[inst] = data;
            if (!cmd[7] && cmd[1:0] == 2'd2) m_ctrl[inst]    = data;
            m_xfer[inst] = m_xfer[inst] + 8'd1;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        wait_clk(4);
        check_bit("miso_z_in_reset", miso_bus, 1'b1);
        rst_n = 1'b1;
        wait_clk(6);
        check_bit("miso_z_after_reset", miso_bus, 1'b1);

        frame(0, 8'h80, 8'h00, 16);
        frame(0, 8'h83, 8'h00, 16);
        frame(0, 8'h01, 8'h3C, 16);
        frame(0, 8'h81, 8'h00, 16);
        frame(0, 8'h83, 8'h00, 16);
        frame(0, 8'h00, 8'hFF, 16);
        frame(0, 8'h80, 8'h00, 16);
        frame(0, 8'h03, 8'h55, 16);
        frame(0, 8'h83, 8'h00, 16);
        frame(0, 8'h02, 8'h99, 12);
        frame(0, 8'h82, 8'h00, 16);
        frame(0, 8'h83, 8'h00, 16);
        frame(1, 8'h80, 8'h00, 16);
        frame(1, 8'h01, 8'hC3, 16);
        frame(1, 8'hFD, 8'h00, 24);
        frame(0, 8'h81, 8'h00, 16);

        for (int n = 0; n < 40; n++) begin
            int inst;
            int nb;
            inst = int'($urandom % 2);
            nb   = ($urandom % 4 == 0) ? int'($urandom_range(0, 24)) : 16;
            frame(inst, 8'($urandom), 8'($urandom), nb);
        end

        // Reset in the middle of a write frame with cs held low
        exp_q.push_back(C_ID0);
        exp_q.push_back(8'h00);
        wait_clk(1);
        cs0 = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 10; i++) sclk_pulse(i == 7);
        wait_clk(2);
        rst_n = 1'b0;
        wait_clk(2);
        check_bit("miso_low_mid_reset", miso_bus, 1'b0);
        model_reset();
        rst_n = 1'b1;
        wait_clk(3);
        for (int i = 0; i < 6; i++) sclk_pulse(1'b1);
        check_bit("miso_low_after_reset", miso_bus, 1'b0);
        wait_clk(6);
        cs0 = 1'b1;
        wait_clk(6);
        check_bit("miso_released_after_reset", miso_bus, 1'b1);

        frame(0, 8'h81, 8'h00, 16);
        frame(0, 8'h83, 8'h00, 16);
        frame(0, 8'h02, 8'h6E, 16);
        frame(0, 8'h82, 8'h00, 16);
        frame(1, 8'h83, 8'h00, 16);

        wait_clk(10);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_bytes got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
